// File: rtl/btn_debounce_rst.sv
// Push-button conditioner: 2-flop synchroniser, stable-time debounce FSM,
// rise/fall strobes and a stretched, retriggerable reset pulse per accepted press.
module btn_debounce_rst #(
    parameter int STABLE_CYCLES  = 1_000_000,
    parameter int RST_PULSE      = 16,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic rst_out
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES);
    localparam int PCNT_W = $clog2(RST_PULSE + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(RST_PULSE);

    typedef enum logic [1:0] {
        S_LOW,
        S_RISE_CHK,
        S_HIGH,
        S_FALL_CHK
    } state_t;

    logic              b;
    logic              s1;
    logic              s2;
    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              rise_next;
    logic              fall_next;
    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_dec;

    assign b = btn_raw ^ BTN_ACTIVE_LOW;

    // synchroniser: only s2 is allowed to reach the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= b;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOW;
            cnt      <= '0;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            btn_rise <= rise_next;
            btn_fall <= fall_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            S_LOW: begin
                if (s2) begin
                    state_next = S_RISE_CHK;
                    cnt_next   = '0;
                end
            end
            S_RISE_CHK: begin
                if (!s2) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s2) begin
                    state_next = S_FALL_CHK;
                    cnt_next   = '0;
                end
            end
            S_FALL_CHK: begin
                if (s2) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    assign btn_level = (state == S_HIGH) || (state == S_FALL_CHK);

    // reset stretcher: a press arriving mid-pulse reloads, so the pulse extends without a gap
    assign pcnt_dec = pcnt - PCNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            rst_out <= 1'b0;
        end else if (rise_next) begin
            pcnt    <= PCNT_LOAD;
            rst_out <= 1'b1;
        end else if (pcnt != '0) begin
            pcnt    <= pcnt_dec;
            rst_out <= (pcnt_dec != '0);
        end else begin
            rst_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_debounce_rst.sv
// Bench for btn_debounce_rst: directed and random button activity, checked per
// cycle against a run-length debounce model through an expected-output queue.
module tb_btn_debounce_rst;

    localparam int STABLE = 8;
    localparam int PULSE  = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_raw_al;
    logic level, rise, fall, rst_o;
    logic level_al, rise_al, fall_al, rst_o_al;

    int tests = 0;
    int fails = 0;

    assign btn_raw_al = ~btn_raw;

    always #5 clk = ~clk;

    btn_debounce_rst #(
        .STABLE_CYCLES(STABLE), .RST_PULSE(PULSE), .BTN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(level), .btn_rise(rise), .btn_fall(fall), .rst_out(rst_o)
    );

    btn_debounce_rst #(
        .STABLE_CYCLES(STABLE), .RST_PULSE(PULSE), .BTN_ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_al),
        .btn_level(level_al), .btn_rise(rise_al), .btn_fall(fall_al), .rst_out(rst_o_al)
    );

    // Reference model: a new level is accepted once the synchronised input has
    // differed from the accepted level for STABLE+1 consecutive FSM samples.
    logic [3:0] exp_q[$];
    bit m_d1, m_d2, m_level, m_prev_rst_n, started;
    int m_run, m_pcnt;

    initial m_prev_rst_n = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        bit fin, m_rise, m_fall;
        if (!rst_n) begin
            m_d1 = 0; m_d2 = 0; m_level = 0; m_run = 0; m_pcnt = 0;
            if (m_prev_rst_n) begin
                exp_q.delete();
                if (clk) exp_q.push_back(4'b0000);
            end else begin
                exp_q.push_back(4'b0000);
                started = 1;
            end
        end else begin
            fin = m_d2;
            m_d2 = m_d1;
            m_d1 = btn_raw;
            m_rise = 0;
            m_fall = 0;
            if (fin != m_level) begin
                m_run++;
                if (m_run == STABLE + 1) begin
                    m_level = !m_level;
                    m_run = 0;
                    m_rise = m_level;
                    m_fall = !m_level;
                end
            end else begin
                m_run = 0;
            end
            if (m_rise) m_pcnt = PULSE;
            else if (m_pcnt > 0) m_pcnt--;
            exp_q.push_back({m_level, m_rise, m_fall, (m_pcnt > 0)});
            started = 1;
        end
        m_prev_rst_n = rst_n;
    end

    task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got {level,rise,fall,rst_out}=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec("cycle_dut", {level, rise, fall, rst_o}, e);
            check_vec("cycle_active_low", {level_al, rise_al, fall_al, rst_o_al}, e);
        end else if (started) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_underflow at %0t: got empty queue expected an entry", $time);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Edges until the chosen strobe is seen (-1 if the budget runs out); returns at posedge+2.
    task automatic edges_to_strobe(input bit want_fall, output int k);
        bit got = 0;
        k = 0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (want_fall ? fall : rise) got = 1;
        end
        if (!got) k = -1;
        #1;
    endtask

    initial begin
        int k, w;
        btn_raw = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_vec("reset_state", {level, rise, fall, rst_o}, 4'b0000);
        tick(3);
        rst_n = 1'b1;
        tick(6);

        // clean press
        btn_raw = 1'b1;
        edges_to_strobe(1'b0, k);
        check_int("press_latency", k, STABLE + 3);
        w = rst_o ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!rst_o) break;
            w++;
        end
        #1;
        check_int("rst_out_width", w, PULSE);
        tick(10);

        // clean release
        btn_raw = 1'b0;
        edges_to_strobe(1'b1, k);
        check_int("release_latency", k, STABLE + 3);
        tick(8);

        // bounce shorter than the stable time
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b1;
            tick(3);
            btn_raw = 1'b0;
            tick(3);
        end
        tick(15);
        check_int("bounce_level", level, 0);

        // glitch during release check
        btn_raw = 1'b1;
        tick(20);
        btn_raw = 1'b0;
        tick(5);
        btn_raw = 1'b1;
        tick(20);
        check_int("glitch_level", level, 1);

        // async reset in the second cycle of rst_out, button held through release
        btn_raw = 1'b0;
        tick(20);
        btn_raw = 1'b1;
        edges_to_strobe(1'b0, k);
        check_int("press2_latency", k, STABLE + 3);
        tick(1);
        rst_n = 1'b0;
        #1;
        check_vec("async_reset_dut", {level, rise, fall, rst_o}, 4'b0000);
        check_vec("async_reset_al", {level_al, rise_al, fall_al, rst_o_al}, 4'b0000);
        #1;
        tick(3);
        rst_n = 1'b1;
        edges_to_strobe(1'b0, k);
        check_int("held_through_reset_latency", k, STABLE + 3);
        tick(20);

        // random activity with occasional resets
        for (int i = 0; i < 200; i++) begin
            btn_raw = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 14));
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
